led_sequencer: RTL and testbench

Button-driven controller that sequences the 3-LED status bank. It debounces the two active-low board buttons and runs a start/pause/stop state machine with a step prescaler. It generates one of three LED patterns (binary count, rotate, ping-pong) and drives the active-low LEDs. It sits directly between the board button/LED pins and the top level.

---
 rtl/led_seq_pkg.sv | 39 +++
 rtl/button_debounce.sv | 66 ++++++
 rtl/led_sequencer.sv | 116 +++++++++++
 tb/tb_led_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_t;

    localparam logic [2:0] PAT_INIT_COUNT  = 3'b000;
    localparam logic [2:0] PAT_INIT_SHIFT  = 3'b001;
    localparam logic [2:0] PAT_INIT_BOUNCE = 3'b001;

    function automatic logic [2:0] init_pattern(input mode_t m);
        case (m)
            MODE_SHIFT:  return PAT_INIT_SHIFT;
            MODE_BOUNCE: return PAT_INIT_BOUNCE;
            default:     return PAT_INIT_COUNT;
        endcase
    endfunction

    // The unused encoding 3 behaves as COUNT, so it advances like COUNT.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_SHIFT:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_COUNT;
            default:     return MODE_SHIFT;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Sync + debounce (LED_SEQ_DEBOUNCE_EN) + falling-edge pulse for one active-low button.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles to the press pulse (2 sync cycles when bypassed).
// Backpressure: none; press is a 1-cycle pulse that is never held off.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    logic [1:0] sync_q;
    logic       level;
    logic       level_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], button};
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          level_q;

    // Any cycle that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign level = level_q;
`else
    // Without debounce the threshold has no effect on the logic.
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_q <= 1'b1;
        end else begin
            level_d_q <= level;
        end
    end

    assign press = level_d_q & ~level;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven start/pause/stop sequencer for the 3-LED bank (debounce via LED_SEQ_DEBOUNCE_EN).
// Latency: state/mode update on the press-pulse edge; led follows the pattern register directly.
// Backpressure: none; a press always acts in the cycle its pulse is high.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WAIT_TIME       = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] button,
    output logic [2:0] led,
    output logic       running,
    output logic [1:0] mode
);

    localparam int PW = $clog2(WAIT_TIME);

    logic [1:0] press;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .button(button[i]),
            .press (press[i])
        );
    end

    state_t        state_q;
    mode_t         mode_q;
    logic [2:0]    pattern_q;
    logic          dir_up_q;
    logic [PW-1:0] presc_q;

    logic          tick;
    logic [2:0]    step_pattern;
    logic          step_dir_up;

    assign tick = (presc_q == PW'(WAIT_TIME - 1));

    // Bounce turns around at either end before shifting, so the ends are never repeated.
    always_comb begin
        step_dir_up  = dir_up_q;
        step_pattern = pattern_q + 3'd1;
        case (mode_q)
            MODE_SHIFT: step_pattern = {pattern_q[1:0], pattern_q[2]};
            MODE_BOUNCE: begin
                if (pattern_q == 3'b100) begin
                    step_dir_up = 1'b0;
                end else if (pattern_q == 3'b001) begin
                    step_dir_up = 1'b1;
                end
                step_pattern = step_dir_up ? (pattern_q << 1) : (pattern_q >> 1);
            end
            default: ;
        endcase
    end

    // Stop (press[1]) has priority over start/next (press[0]) and over a step tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_COUNT;
            pattern_q <= 3'b000;
            dir_up_q  <= 1'b1;
            presc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press[0] && !press[1]) begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        pattern_q <= init_pattern(mode_q);
                        dir_up_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (press[1]) begin
                        state_q <= PAUSE;
                    end else if (press[0]) begin
                        mode_q    <= next_mode(mode_q);
                        pattern_q <= init_pattern(next_mode(mode_q));
                        dir_up_q  <= 1'b1;
                        presc_q   <= '0;
                    end else if (tick) begin
                        presc_q   <= '0;
                        pattern_q <= step_pattern;
                        dir_up_q  <= step_dir_up;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (press[1]) begin
                        state_q   <= IDLE;
                        pattern_q <= 3'b000;
                        dir_up_q  <= 1'b1;
                        presc_q   <= '0;
                    end else if (press[0]) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led     = ~pattern_q;
    assign running = (state_q == RUN);
    assign mode    = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed + random stimulus against a table-driven reference of the LED sequencer.
module tb_led_sequencer;

    localparam int W = 4;
    localparam int N = 3;
`ifdef LED_SEQ_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    // Edges from the first edge that samples a pressed raw level to the edge the FSM reacts on.
    localparam int LAT = DEB ? 2 + N : 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button;
    logic [2:0] led;
    logic       running;
    logic [1:0] mode;

    always #5 clk = ~clk;

    led_sequencer #(
        .WAIT_TIME      (W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button),
        .led    (led),
        .running(running),
        .mode   (mode)
    );

    int tests = 0;
    int fails = 0;

    // Reference: per-button raw history and accepted level; sequencer as state/mode/step index/phase.
    int m_s0 [2];
    int m_s1 [2];
    int m_lvl[2];
    int m_last[2];
    int m_run[2];
    int st, md, idx, ph;

    function automatic int pat();
        int b4 [4] = '{1, 2, 4, 2};
        if (st == 0) return 0;
        case (md)
            1:       return 1 << (idx % 3);
            2:       return b4[idx % 4];
            default: return idx % 8;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s0[b] = 1; m_s1[b] = 1; m_lvl[b] = 1; m_last[b] = 1; m_run[b] = 0;
        end
        st = 0; md = 0; idx = 0; ph = 0;
    endtask

    task automatic model_edge();
        int p [2];
        for (int b = 0; b < 2; b++)
            p[b] = (m_last[b] == 1 && (DEB ? m_lvl[b] : m_s1[b]) == 0) ? 1 : 0;
        if (p[1] == 1) begin
            if (st == 1) st = 2;
            else if (st == 2) begin st = 0; idx = 0; ph = 0; end
        end else if (p[0] == 1) begin
            if (st == 0) begin st = 1; idx = 0; ph = 0; end
            else if (st == 1) begin md = (md + 1) % 3; idx = 0; ph = 0; end
            else st = 1;
        end else if (st == 1) begin
            if (ph == W - 1) begin ph = 0; idx++; end
            else ph++;
        end
        for (int b = 0; b < 2; b++) begin
            if (DEB) begin
                m_last[b] = m_lvl[b];
                if (m_s1[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == N) begin m_lvl[b] = m_s1[b]; m_run[b] = 0; end
                end else begin
                    m_run[b] = 0;
                end
            end else begin
                m_last[b] = m_s1[b];
            end
            m_s1[b] = m_s0[b];
            m_s0[b] = int'(button[b]);
        end
    endtask

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic cyc();
        logic [2:0] el;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        el = ~3'(pat());
        check("led", led, el);
        check("running", {2'b00, running}, (st == 1) ? 3'd1 : 3'd0);
        check("mode", {1'b0, mode}, 3'(md));
    endtask

    task automatic drive(input int b, input int hold);
        button[b] = 1'b0;
        repeat (hold) cyc();
        button[b] = 1'b1;
    endtask

    task automatic press(input int b);
        drive(b, N + 1);
        repeat (LAT + N + 2) cyc();
    endtask

    initial begin
        int found;
        int res_c;
        int step_c;
        logic [2:0] prev_led;

        // Reset values appear without any clock edge.
        rst_n  = 1'b0;
        button = 2'b11;
        model_reset();
        #1;
        check("reset_led", led, 3'b111);
        check("reset_running", {2'b00, running}, 3'd0);
        check("reset_mode", {1'b0, mode}, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc();

        // Count mode including 111 -> 000 wrap.
        press(0);
        check("count_running", {2'b00, running}, 3'd1);
        repeat (40) cyc();

        // Asynchronous reset in RUN while the pattern is 101.
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            if (st == 1 && md == 0 && idx % 8 == 5) found = 1;
            else cyc();
        end
        check("reach_101", 3'(found), 3'd1);
        check("led_at_101", led, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_led", led, 3'b111);
        check("midrun_reset_running", {2'b00, running}, 3'd0);
        check("midrun_reset_mode", {1'b0, mode}, 3'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Short glitch is rejected when debounced; a 3-cycle press is accepted.
        drive(0, 2);
        repeat (LAT + N + 4) cyc();
        check("glitch_running", {2'b00, running}, DEB ? 3'd0 : 3'd1);
        drive(0, 3);
        repeat (LAT + N + 4) cyc();
        check("accept_running", {2'b00, running}, 3'd1);
        if (DEB) check("accept_mode", {1'b0, mode}, 3'd0);

        // Mode cycling through SHIFT and BOUNCE.
        press(0);
        check("mode_shift", {1'b0, mode}, 3'd1 + (DEB ? 3'd0 : 3'd1));
        repeat (16) cyc();
        if (!DEB) press(0);
        press(0);
        check("mode_bounce", {1'b0, mode}, 3'd0 + (DEB ? 3'd2 : 3'd1));
        repeat (24) cyc();
        // Bring the bypass build onto the same mode as the debounced build.
        while (md != 2 && tests < 100000) press(0);
        check("mode_is_bounce", {1'b0, mode}, 3'd2);

        // Pause with the prescaler at 2, then resume: step lands 2 cycles after resume.
        found = 0;
        for (int i = 0; i < 2 * W && found == 0; i++) begin
            if ((ph + LAT) % W == 2) found = 1;
            else cyc();
        end
        press(1);
        check("pause_running", {2'b00, running}, 3'd0);
        repeat (12) cyc();
        res_c  = -1;
        step_c = -1;
        button[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == N + 1) button[0] = 1'b1;
            prev_led = led;
            cyc();
            if (res_c < 0 && running) res_c = i;
            else if (res_c >= 0 && step_c < 0 && led != prev_led) step_c = i;
        end
        check("resume_step_delay", (res_c >= 0 && step_c >= 0) ? 3'(step_c - res_c) : 3'd7, 3'd2);

        // Stop: RUN -> PAUSE -> IDLE, mode retained.
        press(1);
        press(1);
        check("stop_led", led, 3'b111);
        check("stop_running", {2'b00, running}, 3'd0);
        check("stop_mode", {1'b0, mode}, 3'd2);

        // Simultaneous presses in RUN: stop wins.
        press(0);
        check("restart_running", {2'b00, running}, 3'd1);
        button = 2'b00;
        repeat (N + 1) cyc();
        button = 2'b11;
        repeat (LAT + N + 2) cyc();
        check("both_running", {2'b00, running}, 3'd0);
        check("both_mode", {1'b0, mode}, 3'd2);

        // Random button activity, checked every cycle against the reference.
        for (int i = 0; i < 300; i++) begin
            button = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 6)) cyc();
        end
        button = 2'b11;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
